// File: rtl/uart_byte_rx_if.sv
// Receive-side handshake bundle for uart_byte_rx: received byte plus its two one-cycle strobes.
interface uart_byte_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    modport master (output rx_data, rx_valid, frame_err);
    modport slave  (input  rx_data, rx_valid, frame_err);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first, fixed baud; one-cycle rx_valid/frame_err strobes, led toggles per good byte.
// Optional UART_RX_MAJORITY_EN: each sample point is a 2-of-3 vote of rx_s at counts T-2, T-1, T.
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           uart_rx,
    output logic           led,
    uart_byte_rx_if.master rx_if
);
    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD - 1;
    localparam int unsigned HALF_CNT     = (BAUD_CNT_MAX + 1) / 2 - 1;
    localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]       r_sync;
    logic             r_rx_d;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_led;
    logic             w_rx_s;
    logic             w_term;
    logic             w_sample;

    assign w_rx_s = r_sync[1];
    assign w_term = (r_state == START) ? (r_cnt == CNT_HALF) : (r_cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], uart_rx};
            r_rx_d <= r_sync[1];
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // r_hist holds rx_s from the two cycles before the terminal count.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '1;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_led   <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (r_rx_d && !w_rx_s) r_state <= START;
                end
                START: begin
                    if (w_term) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_sample ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_term) begin
                        r_cnt   <= '0;
                        r_shift <= {w_sample, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_term) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_sample) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_led   <= ~r_led;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign rx_if.rx_data   = r_data;
    assign rx_if.rx_valid  = r_valid;
    assign rx_if.frame_err = r_ferr;
    assign led             = r_led;
endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 50 clocks per bit (CLK_FREQ=5000, BAUD=100).
// Define UART_RX_MAJORITY_EN for both files to exercise the glitch-rejecting build.
module tb_uart_byte_rx;
    localparam int unsigned CLK_FREQ = 5000;
    localparam int unsigned BAUD     = 100;
    localparam int          BIT      = 50;
    // Strobe lands 478 cycles after the pin falls: 2 sync + 1 detect + 25 start + 9*50 bits.
    localparam int unsigned STROBE_DLY = 478;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic uart_rx = 1'b1;
    logic led;

    uart_byte_rx_if rx_if ();

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .led     (led),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    int unsigned n_ferr = 0;
    int unsigned last_strobe_cyc = 0;
    logic        prev_strobe = 1'b0;
    logic [7:0]  rxq[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_if.rx_valid || rx_if.frame_err) begin
            check("strobe_excl", {30'd0, rx_if.rx_valid & rx_if.frame_err, prev_strobe}, 32'd0);
            last_strobe_cyc = cyc;
        end
        if (rx_if.rx_valid) rxq.push_back(rx_if.rx_data);
        if (rx_if.frame_err) n_ferr++;
        prev_strobe = rx_if.rx_valid | rx_if.frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_len,
                              input bit glitch, input int rst_at, output int unsigned start_cyc);
        int   b;
        logic v;
        start_cyc = 0;
        for (int i = 0; i < 10 * bit_len; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            b = i / bit_len;
            if (b == 0) v = 1'b0;
            else if (b == 9) v = stop_bit;
            else v = data[b-1];
            if (glitch && b >= 1 && b <= 8 && i == 75 + BIT * (b - 1)) v = ~v;
            if (i == rst_at) rst = 1'b0;
            uart_rx = v;
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 'x;
        if (rxq.size() > 0) got = rxq.pop_front();
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    int unsigned t0;
    int unsigned fe0;
    logic [7:0]  glitch_exp;

    initial begin
        repeat (4) @(negedge clk);
        check("rst_data", {24'd0, rx_if.rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        check("rst_led", {31'd0, led}, 32'd1);
        rst = 1'b1;
        idle(20);

        send_frame(8'h55, 1'b1, BIT, 1'b0, -1, t0);
        idle(40);
        check("good55_cnt", rxq.size(), 32'd1);
        check_rx("good55_data", 8'h55);
        check("good55_time", last_strobe_cyc - t0, STROBE_DLY);
        check("good55_led", {31'd0, led}, 32'd0);
        check("good55_reg", {24'd0, rx_if.rx_data}, 32'h55);

        send_frame(8'hA3, 1'b1, BIT, 1'b0, -1, t0);
        idle(40);
        check_rx("goodA3_data", 8'hA3);
        check("goodA3_led", {31'd0, led}, 32'd1);
        check("good_no_ferr", n_ferr, 32'd0);

        send_frame(8'h3C, 1'b0, BIT, 1'b0, -1, t0);
        idle(40);
        check("ferr_cnt", n_ferr, 32'd1);
        check("ferr_time", last_strobe_cyc - t0, STROBE_DLY);
        check("ferr_no_valid", rxq.size(), 32'd0);
        check("ferr_keep_data", {24'd0, rx_if.rx_data}, 32'hA3);
        check("ferr_led", {31'd0, led}, 32'd1);

        @(negedge clk);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        idle(600);
        check("false_start_valid", rxq.size(), 32'd0);
        check("false_start_ferr", n_ferr, 32'd1);

        for (int r = 0; r < 3; r++) begin
            int bl;
            bl = (r == 0) ? BIT : (r == 1) ? BIT + 1 : BIT - 1;
            send_frame(8'h00, 1'b1, bl, 1'b0, -1, t0);
            send_frame(8'hFF, 1'b1, bl, 1'b0, -1, t0);
            send_frame(8'h81, 1'b1, bl, 1'b0, -1, t0);
            idle(60);
            check($sformatf("b2b%0d_cnt", bl), rxq.size(), 32'd3);
            check_rx($sformatf("b2b%0d_00", bl), 8'h00);
            check_rx($sformatf("b2b%0d_FF", bl), 8'hFF);
            check_rx($sformatf("b2b%0d_81", bl), 8'h81);
        end
        check("b2b_led", {31'd0, led}, 32'd0);
        check("b2b_ferr", n_ferr, 32'd1);

        send_frame(8'h96, 1'b1, BIT, 1'b0, 275, t0);
        repeat (5) @(negedge clk);
        check("midrst_data", {24'd0, rx_if.rx_data}, 32'h00);
        check("midrst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("midrst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        check("midrst_led", {31'd0, led}, 32'd1);
        rst = 1'b1;
        idle(30);
        check("midrst_no_strobe", rxq.size(), 32'd0);
        send_frame(8'h5A, 1'b1, BIT, 1'b0, -1, t0);
        idle(40);
        check("after_rst_cnt", rxq.size(), 32'd1);
        check_rx("after_rst_data", 8'h5A);
        check("after_rst_led", {31'd0, led}, 32'd0);

        fe0 = n_ferr;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (1500) @(negedge clk);
        idle(100);
        check("break_ferr", n_ferr - fe0, 32'd1);
        check("break_valid", rxq.size(), 32'd0);
        send_frame(8'h11, 1'b1, BIT, 1'b0, -1, t0);
        idle(40);
        check_rx("post_break_data", 8'h11);
        check("post_break_led", {31'd0, led}, 32'd1);

`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'hC3;
`else
        glitch_exp = 8'h3C;
`endif
        send_frame(8'hC3, 1'b1, BIT, 1'b1, -1, t0);
        idle(40);
        check("glitch_cnt", rxq.size(), 32'd1);
        check_rx("glitch_data", glitch_exp);
        check("glitch_led", {31'd0, led}, 32'd0);
        check("final_ferr", n_ferr - fe0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
